// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver (filter, deframe, make/break event FIFO).
// Optional: define PS2_RX_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_scan_rx #(
   parameter int CODE_BYTES  = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [CODE_BYTES*8-1:0]       code,
   output logic                          byte_valid,
   output logic [7:0]                    byte_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [9:0]                    ev_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err
);
   localparam int CW = CODE_BYTES * 8;
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    s1, s2, filt;
   logic [FW-1:0] fcnt [2];
   logic          clk_d, fall, din;
   state_t        state, state_nx;
   logic [TW-1:0] to_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par, par_ok, timeout, accept, bad;
   logic          ext, brk, push, pop, wr, full;
   logic [9:0]    push_word;
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rp, wp;

   // two-flop synchroniser plus stability filter on both lines, idle high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1      <= '1;
         s2      <= '1;
         filt    <= '1;
         clk_d   <= 1'b1;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         s1    <= {ps2_clk, ps2_data};
         s2    <= s1;
         clk_d <= filt[1];
         for (int i = 0; i < 2; i++)
            if (s2[i] == filt[i])
               fcnt[i] <= '0;
            else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
               filt[i] <= s2[i];
               fcnt[i] <= '0;
            end else
               fcnt[i] <= fcnt[i] + 1'b1;
      end

   assign fall    = clk_d & ~filt[1];
   assign din     = filt[0];
   assign timeout = state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1);

`ifdef PS2_RX_PARITY_CHECK_EN
   assign par_ok = ^{shreg, par};
`else
   assign par_ok = par | 1'b1;
`endif

   // frame state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // frame sequencing on filtered clock falls, aborted by the inactivity timer
   always_comb begin
      state_nx = state;
      if (timeout)
         state_nx = IDLE;
      else if (fall)
         case (state)
            IDLE:    state_nx = din ? IDLE : DATA;
            DATA:    state_nx = bit_cnt == 3'd7 ? PARITY : DATA;
            PARITY:  state_nx = STOP;
            default: state_nx = IDLE;
         endcase
   end

   // stop-bit verdict: accept a clean frame, flag a bad one or a stall
   always_comb begin
      accept = state == STOP && fall && din && par_ok;
      bad    = timeout || (state == STOP && fall && !(din && par_ok));
   end

   // shift register, bit counter, parity capture and inactivity timer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         to_cnt  <= '0;
      end else begin
         to_cnt <= (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
         if (fall && state == IDLE)
            bit_cnt <= '0;
         if (fall && state == DATA) begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fall && state == PARITY)
            par <= din;
      end

   // accepted byte outputs and the legacy raw-byte history
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         byte_valid <= 1'b0;
         byte_data  <= '0;
         code       <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= accept;
         frame_err  <= bad;
         if (accept) begin
            byte_data <= shreg;
            code      <= CW'({code, shreg});
         end
      end

   assign push      = byte_valid && byte_data != 8'hE0 && byte_data != 8'hF0;
   assign push_word = {ext, brk, byte_data};

   // prefix flags accumulate until a non-prefix byte closes the event
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_valid) begin
         ext <= byte_data == 8'hE0 ? 1'b1 : (byte_data == 8'hF0 ? ext : 1'b0);
         brk <= byte_data == 8'hF0 ? 1'b1 : (byte_data == 8'hE0 ? brk : 1'b0);
      end

   assign full     = fifo_count == (AW + 1)'(FIFO_DEPTH);
   assign ev_valid = fifo_count != '0;
   assign pop      = ev_ready && ev_valid;
   assign wr       = push && (!full || pop);

   // event storage
   always_ff @(posedge clk)
      if (wr) mem[wp] <= push_word;

   // pointers, occupancy and a registered head that survives draining
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rp         <= '0;
         wp         <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         ev_data    <= '0;
      end else begin
         overflow   <= push && full && !pop;
         fifo_count <= fifo_count + (AW + 1)'(wr) - (AW + 1)'(pop);
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (pop && fifo_count > (AW + 1)'(1))
            ev_data <= mem[rp + 1'b1];
         else if (wr && (fifo_count == '0 || pop))
            ev_data <= push_word;
      end
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: vector table, corner sequences and random frames vs a byte-history model.
module tb_ps2_scan_rx;
   localparam int CB = 2, FL = 8, TO = 1500, DEPTH = 8, HALF = 20;
`ifdef PS2_RX_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic rdy = 1'b0, rnd_rdy = 1'b0, rnd_bit = 1'b0, ev_ready;
   logic [CB*8-1:0] code;
   logic byte_valid, ev_valid, overflow, frame_err;
   logic [7:0] byte_data;
   logic [9:0] ev_data;
   logic [$clog2(DEPTH):0] fifo_count;

   assign ev_ready = rnd_rdy ? rnd_bit : rdy;
   always #5 clk = ~clk;

   ps2_scan_rx #(.CODE_BYTES(CB), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code(code), .byte_valid(byte_valid), .byte_data(byte_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
      .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err));

   int tests = 0, fails = 0;
   int n_bv = 0, n_err = 0, n_ovf = 0, m_bv = 0, m_err = 0;
   longint cyc = 0, err_cyc = 0, last_fall = 0;
   logic [9:0] got_ev[$], exp_ev[$];
   logic [7:0] acc[$];
   bit m_ext = 1'b0, m_brk = 1'b0;

   typedef struct {
      logic [7:0]  b;
      bit          bad_par;
      bit          bad_stop;
      bit          glitch;
      logic [15:0] code;
      int          bv;
      int          err;
   } vec_t;
   vec_t tbl[9];

   always @(posedge clk) cyc++;
   always @(posedge clk) rnd_bit <= 1'($urandom);

   always @(negedge clk)
      if (rst_n) begin
         if (byte_valid) n_bv++;
         if (frame_err) begin n_err++; err_cyc = cyc; end
         if (overflow) n_ovf++;
         if (ev_valid && ev_ready) got_ev.push_back(ev_data);
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference: frame verdict, raw byte history, prefix grouping into events
   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      if (bad_stop || (PAR_EN && bad_par)) begin
         m_err++;
         return;
      end
      m_bv++;
      acc.push_back(b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         exp_ev.push_back({m_ext, m_brk, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   function automatic logic [CB*8-1:0] model_code();
      logic [CB*8-1:0] r = '0;
      for (int k = 0; k < CB && k < acc.size(); k++) r[8*k +: 8] = acc[acc.size()-1-k];
      return r;
   endfunction

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (glitch && (i == 2 || i == 7)) begin
            tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(HALF - 8);
         end else tick(HALF);
         ps2_clk = 1'b0;
         last_fall = cyc;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
      send_bits(b, bad_par, bad_stop, 11, glitch);
      tick(4);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_code"}, 32'(code), 0);
      check({tag, "_byte_valid"}, 32'(byte_valid), 0);
      check({tag, "_byte_data"}, 32'(byte_data), 0);
      check({tag, "_ev_valid"}, 32'(ev_valid), 0);
      check({tag, "_ev_data"}, 32'(ev_data), 0);
      check({tag, "_fifo_count"}, 32'(fifo_count), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
      check({tag, "_frame_err"}, 32'(frame_err), 0);
   endtask

   initial begin
      int bv0, er0, ov0;
      logic [7:0] b;
      bit bp, bs;
      tbl[0] = '{8'h1C, 0, 0, 0, 16'h001C, 1, 0};
      tbl[1] = '{8'hF0, 0, 0, 0, 16'h1CF0, 1, 0};
      tbl[2] = '{8'h1C, 0, 0, 0, 16'hF01C, 1, 0};
      tbl[3] = '{8'hE0, 0, 0, 0, 16'h1CE0, 1, 0};
      tbl[4] = '{8'hF0, 0, 0, 0, 16'hE0F0, 1, 0};
      tbl[5] = '{8'h75, 0, 0, 0, 16'hF075, 1, 0};
      tbl[6] = '{8'h6B, 0, 1, 0, 16'hF075, 0, 1};
      tbl[7] = '{8'h1C, 1, 0, 0, PAR_EN ? 16'hF075 : 16'h751C, PAR_EN ? 0 : 1, PAR_EN ? 1 : 0};
      tbl[8] = '{8'h2A, 0, 0, 1, PAR_EN ? 16'h752A : 16'h1C2A, 1, 0};

      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      rdy = 1'b1;
      tick(5);

      for (int i = 0; i < 9; i++) begin
         bv0 = n_bv; er0 = n_err;
         send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, tbl[i].glitch);
         model_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
         check($sformatf("vec%0d_code", i), 32'(code), 32'(tbl[i].code));
         check($sformatf("vec%0d_byte_valid", i), n_bv - bv0, tbl[i].bv);
         check($sformatf("vec%0d_frame_err", i), n_err - er0, tbl[i].err);
         if (tbl[i].bv == 1) check($sformatf("vec%0d_byte_data", i), 32'(byte_data), 32'(tbl[i].b));
      end
      tick(5);
      check("vec_ev_count", got_ev.size(), exp_ev.size());
      if (got_ev.size() >= 3) begin
         check("vec_ev0", 32'(got_ev[0]), 32'h01C);
         check("vec_ev1", 32'(got_ev[1]), 32'h11C);
         check("vec_ev2", 32'(got_ev[2]), 32'h375);
      end

      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(3))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         bp = $urandom_range(7) == 0;
         bs = $urandom_range(9) == 0;
         send_frame(b, bp, bs, 1'($urandom));
         model_frame(b, bp, bs);
         check($sformatf("rnd%0d_code", i), 32'(code), 32'(model_code()));
         check($sformatf("rnd%0d_bv_total", i), n_bv, m_bv);
         check($sformatf("rnd%0d_err_total", i), n_err, m_err);
         if (acc.size() > 0) check($sformatf("rnd%0d_byte_data", i), 32'(byte_data), 32'(acc[$]));
      end
      rnd_rdy = 1'b0;
      tick(10);
      check("rnd_ev_count", got_ev.size(), exp_ev.size());
      for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++)
         check($sformatf("rnd_ev%0d", i), 32'(got_ev[i]), 32'(exp_ev[i]));

      er0 = n_err;
      send_bits(8'h1C, 1'b0, 1'b0, 5, 1'b0);
      tick(TO + 40);
      check("timeout_err", n_err - er0, 1);
      check("timeout_latency_ok", 32'(err_cyc - last_fall >= TO && err_cyc - last_fall <= TO + FL + 10), 1);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      model_frame(8'h1C, 1'b0, 1'b0);
      check("post_timeout_code", 32'(code), 32'(model_code()));
      check("post_timeout_byte", 32'(byte_data), 32'h1C);

      tick(5);
      got_ev.delete();
      exp_ev.delete();
      rdy = 1'b0;
      ov0 = n_ovf;
      for (int i = 0; i < 9; i++) begin
         send_frame(8'h15 + 8'(i), 1'b0, 1'b0, 1'b0);
         model_frame(8'h15 + 8'(i), 1'b0, 1'b0);
      end
      @(negedge clk);
      check("fifo_full_count", 32'(fifo_count), DEPTH);
      check("fifo_full_valid", 32'(ev_valid), 1);
      check("fifo_overflow", n_ovf - ov0, 1);
      check("fifo_head", 32'(ev_data), 32'h015);
      rdy = 1'b1;
      tick(DEPTH + 4);
      check("fifo_drain_count", 32'(fifo_count), 0);
      check("fifo_drain_valid", 32'(ev_valid), 0);
      check("fifo_hold_head", 32'(ev_data), 32'h01C);
      check("fifo_pop_count", got_ev.size(), DEPTH);
      for (int i = 0; i < got_ev.size() && i < DEPTH; i++) begin
         check($sformatf("fifo_pop%0d", i), 32'(got_ev[i]), 32'h015 + i);
         check($sformatf("fifo_pop%0d_model", i), 32'(got_ev[i]), 32'(exp_ev[i]));
      end

      send_bits(8'h5A, 1'b0, 1'b0, 6, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      acc.delete();
      got_ev.delete();
      exp_ev.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      model_frame(8'h1C, 1'b0, 1'b0);
      tick(5);
      check("postreset_code", 32'(code), 32'(model_code()));
      check("postreset_byte", 32'(byte_data), 32'h1C);
      check("postreset_ev_count", got_ev.size(), 1);
      if (got_ev.size() == 1) check("postreset_ev", 32'(got_ev[0]), 32'h01C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
